// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register target.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        REG,
        DATA,
        READ,
        WAIT_STOP
    } state_t;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam int unsigned I2C_ADDR_W = 7;
    localparam int unsigned I2C_BYTE_W = 8;
    localparam int unsigned RW_BIT     = 0;

endpackage

// File: rtl/i2c_register_slave_if.sv
// Register-file port between the I2C target and the external register file.
interface i2c_register_slave_if;
    import i2c_pkg::*;

    logic [I2C_BYTE_W-1:0] regRData;
    logic [I2C_BYTE_W-1:0] regAddr;
    logic [I2C_BYTE_W-1:0] regWData;
    logic                  regWrite;
    logic                  regRead;

    modport master (
        input  regRData,
        output regAddr,
        output regWData,
        output regWrite,
        output regRead
    );

    modport slave (
        output regRData,
        input  regAddr,
        input  regWData,
        input  regWrite,
        input  regRead
    );
endinterface

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers with SCL edge and START/STOP condition detection.
module i2c_bus_sync #(
    parameter int unsigned syncStages = 2
) (
    input  logic refClock,
    input  logic reset_n,
    input  logic scl,
    input  logic sda,
    output logic sclRise,
    output logic sclFall,
    output logic startDet,
    output logic stopDet,
    output logic sdaSync
);

    logic [syncStages-1:0] scl_sr;
    logic [syncStages-1:0] sda_sr;
    logic                  scl_prev;
    logic                  sda_prev;
    logic                  scl_s;

    // Idle bus level is high, so everything resets to 1 to avoid false edges.
    always_ff @(posedge refClock) begin
        if (!reset_n) begin
            scl_sr   <= '1;
            sda_sr   <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sr   <= {scl_sr[syncStages-2:0], scl};
            sda_sr   <= {sda_sr[syncStages-2:0], sda};
            scl_prev <= scl_sr[syncStages-1];
            sda_prev <= sda_sr[syncStages-1];
        end
    end

    assign scl_s    = scl_sr[syncStages-1];
    assign sdaSync  = sda_sr[syncStages-1];
    assign sclRise  = scl_s && !scl_prev;
    assign sclFall  = !scl_s && scl_prev;
    assign startDet = scl_s && scl_prev && sda_prev && !sdaSync;
    assign stopDet  = scl_s && scl_prev && !sda_prev && sdaSync;

endmodule

// File: rtl/i2c_register_slave.sv
// I2C register target: pointer-then-data writes, pointer-then-repeated-START reads.
module i2c_register_slave
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] slaveAddress = 7'h39,
    parameter int unsigned           syncStages   = 2
) (
    input  logic                  refClock,
    input  logic                  reset_n,
    input  logic                  scl,
    inout  wire                   sda,
    i2c_register_slave_if.master  regs,
    output logic                  busy,
    output logic                  transactionDone
);

    logic sclRise, sclFall, startDet, stopDet, sdaSync;

    i2c_bus_sync #(.syncStages(syncStages)) u_sync (
        .refClock (refClock),
        .reset_n  (reset_n),
        .scl      (scl),
        .sda      (sda),
        .sclRise  (sclRise),
        .sclFall  (sclFall),
        .startDet (startDet),
        .stopDet  (stopDet),
        .sdaSync  (sdaSync)
    );

    state_t                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [I2C_BYTE_W-1:0] shift_q, shift_d;
    logic [I2C_BYTE_W-1:0] addr_q, addr_d;
    logic [I2C_BYTE_W-1:0] wdata_q, wdata_d;
    logic                  sda_low_q, sda_low_d;
    logic                  ack_phase_q, ack_phase_d;
    logic                  ack_hold_q, ack_hold_d;
    logic                  mack_q, mack_d;
    logic                  load_pend_q, load_pend_d;
    logic                  write_q, write_d;
    logic                  read_q, read_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [I2C_BYTE_W-1:0] byte_in;

    assign byte_in = {shift_q[I2C_BYTE_W-2:0], sdaSync};

    always_ff @(posedge refClock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            sda_low_q   <= 1'b0;
            ack_phase_q <= 1'b0;
            ack_hold_q  <= 1'b0;
            mack_q      <= 1'b0;
            load_pend_q <= 1'b0;
            write_q     <= 1'b0;
            read_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            sda_low_q   <= sda_low_d;
            ack_phase_q <= ack_phase_d;
            ack_hold_q  <= ack_hold_d;
            mack_q      <= mack_d;
            load_pend_q <= load_pend_d;
            write_q     <= write_d;
            read_q      <= read_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        sda_low_d   = sda_low_q;
        ack_phase_d = ack_phase_q;
        ack_hold_d  = ack_hold_q;
        mack_d      = mack_q;
        load_pend_d = 1'b0;
        write_d     = 1'b0;
        read_d      = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;

        // Pointer advances the cycle after the write strobe so the strobe sees the old address.
        if (write_q) begin
            addr_d = addr_q + 8'd1;
        end

        if (startDet) begin
            state_d     = ADDR;
            cnt_d       = '0;
            sda_low_d   = 1'b0;
            ack_phase_d = 1'b0;
            ack_hold_d  = 1'b0;
            mack_d      = 1'b0;
        end else if (stopDet) begin
            state_d     = IDLE;
            cnt_d       = '0;
            sda_low_d   = 1'b0;
            ack_phase_d = 1'b0;
            ack_hold_d  = 1'b0;
            mack_d      = 1'b0;
            busy_d      = 1'b0;
            done_d      = busy_q;
        end else if (state_q != IDLE) begin
            // regRData follows regAddr combinationally, so load one cycle after the increment.
            if (load_pend_q) begin
                shift_d = regs.regRData;
                read_d  = 1'b1;
            end

            if (sclFall) begin
                if (ack_phase_q) begin
                    sda_low_d   = 1'b1;
                    ack_phase_d = 1'b0;
                    ack_hold_d  = 1'b1;
                end else if (ack_hold_q) begin
                    ack_hold_d = 1'b0;
                    sda_low_d  = (state_q == READ) && !shift_q[I2C_BYTE_W-1];
                end else if (state_q == READ) begin
                    sda_low_d = !mack_q && !shift_q[I2C_BYTE_W-1];
                end
            end

            // The 9th (ACK) clock is not a data bit, hence the ack_phase/ack_hold gating.
            if (sclRise && !ack_phase_q && !ack_hold_q) begin
                case (state_q)
                    ADDR, REG, DATA: begin
                        shift_d = byte_in;
                        if (cnt_q == 3'd7) begin
                            cnt_d = '0;
                            if (state_q == ADDR) begin
                                if (byte_in[I2C_BYTE_W-1:1] == slaveAddress) begin
                                    busy_d      = 1'b1;
                                    ack_phase_d = 1'b1;
                                    if (byte_in[RW_BIT]) begin
                                        state_d = READ;
                                        shift_d = regs.regRData;
                                        read_d  = 1'b1;
                                    end else begin
                                        state_d = REG;
                                    end
                                end else begin
                                    state_d = IDLE;
                                end
                            end else if (state_q == REG) begin
                                addr_d      = byte_in;
                                state_d     = DATA;
                                ack_phase_d = 1'b1;
                            end else begin
                                wdata_d     = byte_in;
                                write_d     = 1'b1;
                                ack_phase_d = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                    READ: begin
                        if (mack_q) begin
                            mack_d = 1'b0;
                            if (sdaSync == ACK) begin
                                addr_d      = addr_q + 8'd1;
                                load_pend_d = 1'b1;
                            end else begin
                                state_d   = WAIT_STOP;
                                sda_low_d = 1'b0;
                            end
                        end else begin
                            shift_d = {shift_q[I2C_BYTE_W-2:0], 1'b0};
                            if (cnt_q == 3'd7) begin
                                cnt_d  = '0;
                                mack_d = 1'b1;
                            end else begin
                                cnt_d = cnt_q + 3'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sda             = sda_low_q ? 1'b0 : 1'bz;
    assign regs.regAddr    = addr_q;
    assign regs.regWData   = wdata_q;
    assign regs.regWrite   = write_q;
    assign regs.regRead    = read_q;
    assign busy            = busy_q;
    assign transactionDone = done_q;

endmodule

// File: tb/tb_i2c_register_slave.sv
// Directed bench for i2c_register_slave acting as the I2C master and register file.
module tb_i2c_register_slave;

    localparam int T = 200;

    logic       refClock = 1'b0;
    logic       reset_n  = 1'b0;
    logic       scl      = 1'b1;
    logic       tb_sda_low = 1'b0;
    wire        sda;
    logic       busy;
    logic       transactionDone;
    logic [7:0] reg_model [256];

    int vectors    = 0;
    int miscompares = 0;

    int         wr_cnt = 0;
    int         rd_cnt = 0;
    int         done_cnt = 0;
    logic [7:0] wr_addr_log [16];
    logic [7:0] wr_data_log [16];

    i2c_register_slave_if regs ();

    assign sda = tb_sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    assign regs.regRData = reg_model[regs.regAddr];

    i2c_register_slave #(.slaveAddress(7'h39), .syncStages(2)) dut (
        .refClock        (refClock),
        .reset_n         (reset_n),
        .scl             (scl),
        .sda             (sda),
        .regs            (regs),
        .busy            (busy),
        .transactionDone (transactionDone)
    );

    always #10 refClock = ~refClock;

    always @(negedge refClock) begin
        if (regs.regWrite) begin
            wr_addr_log[wr_cnt % 16] <= regs.regAddr;
            wr_data_log[wr_cnt % 16] <= regs.regWData;
            wr_cnt <= wr_cnt + 1;
        end
        if (regs.regRead) rd_cnt <= rd_cnt + 1;
        if (transactionDone) done_cnt <= done_cnt + 1;
    end

    task automatic i2c_start();
        tb_sda_low = 1'b0; #T;
        scl = 1'b1;        #T;
        tb_sda_low = 1'b1; #T;
        scl = 1'b0;        #T;
    endtask

    task automatic i2c_stop();
        tb_sda_low = 1'b1; #T;
        scl = 1'b1;        #T;
        tb_sda_low = 1'b0; #(2*T);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            tb_sda_low = !b[7-i]; #T;
            scl = 1'b1;           #(2*T);
            scl = 1'b0;           #T;
        end
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        send_bits(b, 8);
        tb_sda_low = 1'b0; #T;
        scl = 1'b1;        #T;
        ack = sda;         #T;
        scl = 1'b0;        #T;
    endtask

    task automatic read_byte(output logic [7:0] b, input logic master_ack);
        for (int i = 7; i >= 0; i--) begin
            tb_sda_low = 1'b0; #T;
            scl = 1'b1;        #T;
            b[i] = sda;        #T;
            scl = 1'b0;        #T;
        end
        tb_sda_low = master_ack; #T;
        scl = 1'b1;              #(2*T);
        scl = 1'b0;
        tb_sda_low = 1'b0;       #T;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #100;
        reset_n = 1'b1;
        #40;
        vectors++; if (regs.regAddr !== 8'h00) begin miscompares++; $display("FAIL reset_regAddr: got %h expected 00", regs.regAddr); end
        vectors++; if (regs.regWData !== 8'h00) begin miscompares++; $display("FAIL reset_regWData: got %h expected 00", regs.regWData); end
        vectors++; if (regs.regWrite !== 1'b0) begin miscompares++; $display("FAIL reset_regWrite: got %b expected 0", regs.regWrite); end
        vectors++; if (regs.regRead !== 1'b0) begin miscompares++; $display("FAIL reset_regRead: got %b expected 0", regs.regRead); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (transactionDone !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", transactionDone); end
        vectors++; if (sda !== 1'b1) begin miscompares++; $display("FAIL reset_sda: got %b expected 1", sda); end
        #(2*T);
    endtask

    task automatic test_single_write(input string tag);
        logic a0, a1, a2;
        int w0, d0;
        w0 = wr_cnt; d0 = done_cnt;
        i2c_start();
        write_byte(8'h72, a0);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL %s_busy_high: got %b expected 1", tag, busy); end
        write_byte(8'h41, a1);
        write_byte(8'h10, a2);
        i2c_stop();
        vectors++; if ({a0, a1, a2} !== 3'b000) begin miscompares++; $display("FAIL %s_acks: got %b expected 000", tag, {a0, a1, a2}); end
        vectors++; if (wr_cnt - w0 !== 1) begin miscompares++; $display("FAIL %s_write_count: got %0d expected 1", tag, wr_cnt - w0); end
        vectors++; if (wr_addr_log[w0 % 16] !== 8'h41) begin miscompares++; $display("FAIL %s_write_addr: got %h expected 41", tag, wr_addr_log[w0 % 16]); end
        vectors++; if (wr_data_log[w0 % 16] !== 8'h10) begin miscompares++; $display("FAIL %s_write_data: got %h expected 10", tag, wr_data_log[w0 % 16]); end
        vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL %s_done_count: got %0d expected 1", tag, done_cnt - d0); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL %s_busy_low: got %b expected 0", tag, busy); end
    endtask

    task automatic test_addr_mismatch();
        logic a;
        int w0, d0;
        w0 = wr_cnt; d0 = done_cnt;
        i2c_start();
        write_byte(8'h74, a);
        vectors++; if (a !== 1'b1) begin miscompares++; $display("FAIL mismatch_nack: got %b expected 1", a); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mismatch_busy: got %b expected 0", busy); end
        i2c_stop();
        vectors++; if (wr_cnt - w0 !== 0) begin miscompares++; $display("FAIL mismatch_writes: got %0d expected 0", wr_cnt - w0); end
        vectors++; if (done_cnt - d0 !== 0) begin miscompares++; $display("FAIL mismatch_done: got %0d expected 0", done_cnt - d0); end
    endtask

    task automatic test_burst_wrap();
        logic [4:0] acks;
        logic [7:0] exp_addr [3];
        logic [7:0] exp_data [3];
        int w0, d0;
        exp_addr = '{8'hFE, 8'hFF, 8'h00};
        exp_data = '{8'hAA, 8'hBB, 8'hCC};
        w0 = wr_cnt; d0 = done_cnt;
        i2c_start();
        write_byte(8'h72, acks[4]);
        write_byte(8'hFE, acks[3]);
        write_byte(8'hAA, acks[2]);
        write_byte(8'hBB, acks[1]);
        write_byte(8'hCC, acks[0]);
        i2c_stop();
        vectors++; if (acks !== 5'b00000) begin miscompares++; $display("FAIL burst_acks: got %b expected 00000", acks); end
        vectors++; if (wr_cnt - w0 !== 3) begin miscompares++; $display("FAIL burst_write_count: got %0d expected 3", wr_cnt - w0); end
        for (int k = 0; k < 3; k++) begin
            vectors++; if (wr_addr_log[(w0 + k) % 16] !== exp_addr[k]) begin miscompares++; $display("FAIL burst_addr%0d: got %h expected %h", k, wr_addr_log[(w0 + k) % 16], exp_addr[k]); end
            vectors++; if (wr_data_log[(w0 + k) % 16] !== exp_data[k]) begin miscompares++; $display("FAIL burst_data%0d: got %h expected %h", k, wr_data_log[(w0 + k) % 16], exp_data[k]); end
        end
        vectors++; if (regs.regAddr !== 8'h01) begin miscompares++; $display("FAIL burst_final_addr: got %h expected 01", regs.regAddr); end
        vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL burst_done: got %0d expected 1", done_cnt - d0); end
    endtask

    task automatic test_pointer_read();
        logic a0, a1, a2;
        logic [7:0] b0, b1;
        int w0, r0;
        reg_model[8'h20] = 8'h5A;
        reg_model[8'h21] = 8'hC3;
        w0 = wr_cnt; r0 = rd_cnt;
        i2c_start();
        write_byte(8'h72, a0);
        write_byte(8'h20, a1);
        i2c_start();
        write_byte(8'h73, a2);
        read_byte(b0, 1'b1);
        read_byte(b1, 1'b0);
        vectors++; if ({a0, a1, a2} !== 3'b000) begin miscompares++; $display("FAIL read_acks: got %b expected 000", {a0, a1, a2}); end
        vectors++; if (b0 !== 8'h5A) begin miscompares++; $display("FAIL read_byte0: got %h expected 5a", b0); end
        vectors++; if (b1 !== 8'hC3) begin miscompares++; $display("FAIL read_byte1: got %h expected c3", b1); end
        vectors++; if (regs.regAddr !== 8'h21) begin miscompares++; $display("FAIL read_final_addr: got %h expected 21", regs.regAddr); end
        vectors++; if (sda !== 1'b1) begin miscompares++; $display("FAIL read_sda_released: got %b expected 1", sda); end
        i2c_stop();
        vectors++; if (rd_cnt - r0 !== 2) begin miscompares++; $display("FAIL read_strobes: got %0d expected 2", rd_cnt - r0); end
        vectors++; if (wr_cnt - w0 !== 0) begin miscompares++; $display("FAIL read_writes: got %0d expected 0", wr_cnt - w0); end
    endtask

    task automatic test_reset_midtransfer();
        logic a0, a1;
        int w0;
        w0 = wr_cnt;
        i2c_start();
        write_byte(8'h72, a0);
        write_byte(8'h41, a1);
        send_bits(8'hF0, 4);
        reset_n = 1'b0; #20;
        reset_n = 1'b1;
        vectors++; if (sda !== 1'b1) begin miscompares++; $display("FAIL rst_mid_sda: got %b expected 1", sda); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        vectors++; if (regs.regAddr !== 8'h00) begin miscompares++; $display("FAIL rst_mid_addr: got %h expected 00", regs.regAddr); end
        tb_sda_low = 1'b0; #T;
        scl = 1'b1;        #(2*T);
        vectors++; if (wr_cnt - w0 !== 0) begin miscompares++; $display("FAIL rst_mid_writes: got %0d expected 0", wr_cnt - w0); end

        // Reset while the target is holding an ACK low.
        i2c_start();
        send_bits(8'h72, 8);
        tb_sda_low = 1'b0; #T;
        vectors++; if (sda !== 1'b0) begin miscompares++; $display("FAIL rst_ack_driven: got %b expected 0", sda); end
        reset_n = 1'b0; #20;
        reset_n = 1'b1;
        vectors++; if (sda !== 1'b1) begin miscompares++; $display("FAIL rst_ack_released: got %b expected 1", sda); end
        scl = 1'b1; #(2*T);
        test_single_write("after_rst");
    endtask

    task automatic test_stop_partial();
        logic a0, a1;
        int w0, d0;
        w0 = wr_cnt; d0 = done_cnt;
        i2c_start();
        write_byte(8'h72, a0);
        write_byte(8'h30, a1);
        send_bits(8'hA5, 4);
        i2c_stop();
        vectors++; if (wr_cnt - w0 !== 0) begin miscompares++; $display("FAIL partial_writes: got %0d expected 0", wr_cnt - w0); end
        vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL partial_done: got %0d expected 1", done_cnt - d0); end
        vectors++; if (regs.regAddr !== 8'h30) begin miscompares++; $display("FAIL partial_addr: got %h expected 30", regs.regAddr); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL partial_busy: got %b expected 0", busy); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) reg_model[i] = 8'(i ^ 8'h96);
        test_reset();
        test_single_write("single");
        test_addr_mismatch();
        test_burst_wrap();
        test_pointer_read();
        test_reset_midtransfer();
        test_stop_partial();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2c_register_slave.md
Name: i2c_register_slave

Overview:
I2C target (responder) that answers the 3-byte register-write transactions our I2C master issues: address byte, register pointer, data, with ACK/NACK handling. It also supports pointer-then-repeated-START reads. It oversamples SCL/SDA on the system reference clock, writes into and reads from an external register file, and drives SDA open-drain only. It is used for loopback verification of the master and for exposing overlay control registers to an external I2C host.

Parameters:
slaveAddress, 7'h39, 7-bit target address; the matching write address byte is 0x72 and the read address byte is 0x73.
syncStages, 2, number of synchronizer flops on SCL and SDA (minimum 2).

Ports:
refClock  input  1  system clock (50 MHz nominal); must be at least 20x the SCL frequency.
reset_n  input  1  reset, synchronous, active-low.
scl  input  1  I2C clock from the bus.
sda  inout  1  I2C data; driven 1'b0 or 1'bz only, never driven 1.
regRData  input  8  read data from the external register file, addressed by regAddr, combinational.
regAddr  output  8  current register pointer.
regWData  output  8  write data.
regWrite  output  1  one-cycle write strobe.
regRead  output  1  one-cycle strobe when a read byte is loaded.
busy  output  1  high while a transaction addressed to this target is in progress.
transactionDone  output  1  one-cycle pulse on STOP ending an addressed transaction.

Behaviour:
- Reset (reset_n low at a refClock edge):
  - state IDLE, sda released, bit counter 0, regAddr 0x00.
  - regWData 0x00; regWrite, regRead, busy and transactionDone all 0.
- Input synchronization and edge detection:
  - SCL and SDA pass through syncStages flops, then a previous-value register is used for edge detect.
  - Bus events are seen syncStages+1 cycles after the pin change.
- START: synchronized SCL high while synchronized SDA falls. STOP: synchronized SCL high while synchronized SDA rises.
- START/STOP precedence: both are evaluated before bit logic and override any state.
  - START (including repeated START) goes to ADDR with the bit counter cleared and sda released.
  - STOP goes to IDLE; transactionDone pulses if busy was high.
- Bit reception: data bits are sampled on the synchronized SCL rising edge, MSB first, into an 8-bit shift register; the counter runs 0 to 7.
- ACK timing: on the SCL falling edge after the 8th bit, sda is pulled low if an ACK is owed. It is released on the next SCL falling edge.
- States:
  - IDLE: ignore the bus except for START.
  - ADDR: receive 8 bits.
    - byte[7:1] == slaveAddress: ACK and set busy=1. R/W=0 goes to REG. R/W=1 loads the shift register from regRData, pulses regRead, and goes to READ.
    - Mismatch: no ACK, go to IDLE; busy stays 0.
  - REG: receive a byte, latch it into regAddr, ACK, go to DATA.
  - DATA:
    - Each received byte: at the rising edge of the 8th bit set regWData = byte and pulse regWrite for one cycle with the current regAddr.
    - regAddr then increments by 1 with wrap 0xFF to 0x00.
    - ACK every byte and stay in DATA.
  - READ:
    - On each SCL falling edge present the next bit: 0 pulls sda low, 1 releases it.
    - After 8 bits release sda and sample the master ACK on the 9th SCL rising edge.
    - ACK (sda low): regAddr+1 (with wrap), load regRData, pulse regRead, continue.
    - NACK: go to WAIT_STOP.
  - WAIT_STOP: sda released; only START or STOP is acted on.
- Partial bytes: a byte cut short by START or STOP produces no regWrite and leaves regAddr unchanged.
- regAddr persistence: regAddr persists across transactions, so a write of the pointer followed by a read works.
- Reset mid-transfer: reset takes priority over everything; sda is released on the same edge.

Decomposition:
- Package i2c_pkg holds:
  - the state encoding (IDLE, ADDR, REG, DATA, READ, WAIT_STOP);
  - ACK=1'b0 and NACK=1'b1;
  - I2C_ADDR_W=7 and I2C_BYTE_W=8;
  - the read/write bit position.
- Sub-module i2c_bus_sync holds the synchronizers, SCL rise/fall detect and START/STOP detect, with outputs sclRise, sclFall, startDet, stopDet and sdaSync.

Test Plan:
1. START, bytes 0x72, 0x41, 0x10, STOP -> target ACKs all three bytes; exactly one regWrite with regAddr=0x41 and regWData=0x10; transactionDone pulses once; busy falls.
2. START, 0x74, STOP -> sda stays released on the 9th clock; no regWrite; busy stays 0; transactionDone stays 0.
3. Burst START, 0x72, 0xFE, 0xAA, 0xBB, 0xCC, STOP -> writes FE=AA, FF=BB, 00=CC (wrap); final regAddr=0x01.
4. START, 0x72, 0x20, repeated START, 0x73; model returns [0x20]=0x5A and [0x21]=0xC3; master ACKs the first byte and NACKs the second -> bus carries 0x5A then 0xC3 MSB first; regRead pulses twice; regAddr=0x21 after the NACK.
5. reset_n low for 1 cycle midway through a DATA byte -> sda released on that edge; state IDLE; no regWrite; a following scenario-1 transaction passes.
6. STOP after 4 bits of a DATA byte -> no regWrite; transactionDone pulses; regAddr unchanged.
